// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with configurable bit period, width, parity and stop bits.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_cfg #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              en,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              parity_err,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_W);

`ifdef UART_RX_MAJORITY_EN
  localparam int VOTE_DLY = 1;
`else
  localparam int VOTE_DLY = 0;
`endif

  localparam logic [CNT_W-1:0] START_PT  = CNT_W'(CLK_DIV / 2 - 1 + VOTE_DLY);
  localparam logic [CNT_W-1:0] BIT_PT    = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               sync_p0;
  logic               sync_p1;
  logic               rx_s;
  logic               smp;
  logic               tick;
  logic               done;
  logic               armed;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx;
  logic               stop_cnt;
  logic               ferr_acc;
  logic [DATA_W-1:0]  shreg;
  logic               par_bit;

  function automatic logic parity_bad(input logic [DATA_W-1:0] d, input logic p);
    logic odd_ones;
    odd_ones = (^d) ^ p;
    if (PARITY == 1) return ~odd_ones;
    else if (PARITY == 2) return odd_ones;
    else return 1'b0;
  endfunction

  assign rx_s = sync_p1;
  assign busy = (state != S_IDLE);

`ifdef UART_RX_MAJORITY_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic hist_p0;
  logic hist_p1;

  // rx_s delayed by one and two cycles, so at mid+1 the vote sees mid-1, mid, mid+1
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_p0 <= 1'b1;
      hist_p1 <= 1'b1;
    end else begin
      hist_p0 <= rx_s;
      hist_p1 <= hist_p0;
    end
  end

  assign smp = maj3(hist_p1, hist_p0, rx_s);
`else
  assign smp = rx_s;
`endif

  always_comb begin
    next_state = state;
    tick       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rx_s && armed) next_state = S_START;
      end
      S_START: begin
        tick = (cnt == START_PT);
        if (tick) next_state = smp ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        tick = (cnt == BIT_PT);
        if (tick && (idx == LAST_IDX)) next_state = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: begin
        tick = (cnt == BIT_PT);
        if (tick) next_state = S_STOP;
      end
      S_STOP: begin
        tick = (cnt == BIT_PT);
        if (tick && (stop_cnt == STOP_LAST)) begin
          next_state = S_IDLE;
          done       = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // p0/p1: two-flop synchroniser; control state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      state      <= S_IDLE;
      armed      <= 1'b1;
      cnt        <= '0;
      idx        <= '0;
      stop_cnt   <= 1'b0;
      ferr_acc   <= 1'b0;
      en         <= 1'b0;
      data       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_p0 <= rx;
      sync_p1 <= sync_p0;
      state   <= next_state;
      en      <= done;

      if ((state == S_IDLE) || tick) cnt <= '0;
      else cnt <= cnt + CNT_W'(1);

      if ((state == S_IDLE) && rx_s) armed <= 1'b1;

      if (state == S_START) begin
        idx      <= '0;
        stop_cnt <= 1'b0;
        ferr_acc <= 1'b0;
      end

      if ((state == S_DATA) && tick) idx <= idx + IDX_W'(1);

      if ((state == S_STOP) && tick) begin
        stop_cnt <= stop_cnt + 1'b1;
        if (!smp) ferr_acc <= 1'b1;
      end

      // A low final stop bit is treated as a break: stay disarmed until the line idles high
      if (done) begin
        data       <= shreg;
        parity_err <= parity_bad(shreg, par_bit);
        frame_err  <= ferr_acc | ~smp;
        armed      <= smp;
      end
    end
  end

  // Datapath capture: LSB-first shift and parity bit
  always_ff @(posedge clk) begin
    if ((state == S_DATA) && tick) shreg <= {smp, shreg[DATA_W-1:1]};
    if ((state == S_PAR) && tick) par_bit <= smp;
  end

endmodule
